memory_unit: RTL and testbench

Word-addressed main memory with a request/ready handshake, sitting directly on the datapath's memory side. It takes the address from MAR and write data from MDR, and returns read data on the bus that feeds the MDR's memory input (MDataIN). The control unit issues one-cycle read/write strobes and waits for `mem_ready` before loading the MDR or advancing. Access latency is parameterised so control-unit wait-state logic can be exercised.

---
 rtl/memory_unit.sv | 100 ++++++++++
 tb/tb_memory_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_unit.sv
// Word-addressed 32-bit memory with read/write strobes; access completes WAIT_CYCLES+1 edges after accept.
// No backpressure queue: requests seen while busy are dropped, mem_ready/mem_err pulse for one cycle.
module memory_unit #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] MAR_Data,
  input  logic [31:0] MDR_Data,
  output logic [31:0] MDataIN,
  output logic        mem_ready,
  output logic        busy,
  output logic        mem_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_op_rd;
  logic              r_op_wr;
  logic              r_err;
  logic [31:0]       r_mem [0:(1<<ADDR_W)-1];

  logic w_accept;
  logic w_req_err;
  logic w_access;

  assign w_accept  = ((r_state == S_IDLE) || (r_state == S_DONE)) && (read || write);
  assign w_req_err = (read && write) || (MAR_Data[31:ADDR_W] != '0);
  assign w_access  = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign MDataIN   = r_rdata;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_DONE;
      S_DONE:  w_next = w_accept ? S_WAIT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state == S_WAIT);
    mem_ready = (r_state == S_DONE);
    mem_err   = (r_state == S_DONE) && r_err;
  end

  // Errored requests still walk the full wait sequence but never touch the array or read data.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_op_rd <= 1'b0;
      r_op_wr <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      if (w_accept) begin
        r_cnt   <= C_WAIT;
        r_addr  <= MAR_Data[ADDR_W-1:0];
        r_wdata <= MDR_Data;
        r_op_rd <= read;
        r_op_wr <= write;
        r_err   <= w_req_err;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access && r_op_rd && !r_err) begin
        r_rdata <= r_mem[r_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_access && r_op_wr && !r_err) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

endmodule

// File: tb/tb_memory_unit.sv
// Scoreboard bench for memory_unit: ops queued at issue, expectations derived from a model memory at completion.
module tb_memory_unit;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  logic        clk = 1'b0;
  logic        clr;
  logic        read;
  logic        write;
  logic [31:0] MAR_Data;
  logic [31:0] MDR_Data;
  logic [31:0] MDataIN;
  logic        mem_ready;
  logic        busy;
  logic        mem_err;

  op_t         sb[$];
  logic [31:0] model [512];
  logic [31:0] exp_rdata;
  int          n_checks = 0;
  int          n_fail   = 0;

  memory_unit #(.ADDR_W(9), .WAIT_CYCLES(2)) dut (
    .clk(clk), .clr(clr), .read(read), .write(write),
    .MAR_Data(MAR_Data), .MDR_Data(MDR_Data),
    .MDataIN(MDataIN), .mem_ready(mem_ready), .busy(busy), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    op_t op;
    read = rd; write = wr; MAR_Data = addr; MDR_Data = data;
    op.rd = rd; op.wr = wr; op.addr = addr; op.data = data;
    sb.push_back(op);
    @(posedge clk);
    @(negedge clk);
    read = 1'b0; write = 1'b0;
  endtask

  task automatic wait_ready(output int lat, output int bsy);
    lat = 0; bsy = 0;
    while (mem_ready !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bsy++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic retire(output logic [31:0] exp_d, output logic exp_e);
    op_t op;
    if (sb.size() == 0) begin
      exp_d = 'x; exp_e = 1'bx;
      return;
    end
    op = sb.pop_front();
    exp_e = (op.rd && op.wr) || (op.addr[31:9] != 23'd0);
    if (!exp_e && op.rd) exp_rdata = model[op.addr[8:0]];
    if (!exp_e && op.wr) model[op.addr[8:0]] = op.data;
    exp_d = exp_rdata;
  endtask

  task automatic test_reset();
    int lat, bsy;
    logic [31:0] ed;
    logic ee;
    clr = 1'b0; read = 1'b0; write = 1'b0; MAR_Data = 32'd0; MDR_Data = 32'd0;
    exp_rdata = 32'd0;
    repeat (3) @(negedge clk);
    n_checks++; if (MDataIN !== 32'd0) begin n_fail++; $display("FAIL reset_mdata: got %h want 0", MDataIN); end
    n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", mem_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", mem_err); end
    clr = 1'b1;
    @(negedge clk);
    // Preload by write sequence.
    issue(1'b0, 1'b1, 32'h005, 32'h12345678); wait_ready(lat, bsy); retire(ed, ee);
    issue(1'b0, 1'b1, 32'h010, 32'hAAAA5555); wait_ready(lat, bsy); retire(ed, ee);
    issue(1'b0, 1'b1, 32'h001, 32'h01010101); wait_ready(lat, bsy); retire(ed, ee);
    issue(1'b0, 1'b1, 32'h002, 32'h02020202); wait_ready(lat, bsy); retire(ed, ee);
    issue(1'b0, 1'b1, 32'h020, 32'h00000000); wait_ready(lat, bsy); retire(ed, ee);
    issue(1'b1, 1'b0, 32'h005, 32'h0); wait_ready(lat, bsy); retire(ed, ee);
    n_checks++; if (MDataIN !== ed) begin n_fail++; $display("FAIL pre_read_data: got %h want %h", MDataIN, ed); end
    @(negedge clk);
    // Reset in the middle of a read's wait sequence.
    issue(1'b1, 1'b0, 32'h001, 32'h0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_read_busy: got %b want 1", busy); end
    #2 clr = 1'b0;
    #1;
    n_checks++; if (MDataIN !== 32'd0) begin n_fail++; $display("FAIL async_mdata: got %h want 0", MDataIN); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_busy: got %b want 0", busy); end
    n_checks++; if (mem_ready !== 1'b0 || mem_err !== 1'b0) begin n_fail++; $display("FAIL async_ready_err: got %b%b want 00", mem_ready, mem_err); end
    sb.delete();
    exp_rdata = 32'd0;
    @(negedge clk);
    clr = 1'b1;
    lat = 0;
    for (int c = 0; c < 6; c++) begin
      if (mem_ready === 1'b1) lat++;
      @(negedge clk);
    end
    n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL abort_no_ready: got %0d pulses want 0", lat); end
    issue(1'b1, 1'b0, 32'h005, 32'h0); wait_ready(lat, bsy); retire(ed, ee);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL post_reset_latency: got %0d want 3", lat); end
    n_checks++; if (MDataIN !== ed || ed !== 32'h12345678) begin n_fail++; $display("FAIL post_reset_data: got %h want 12345678 (model %h)", MDataIN, ed); end
    n_checks++; if (mem_err !== ee) begin n_fail++; $display("FAIL post_reset_err: got %b want %b", mem_err, ee); end
  endtask

  task automatic test_write_read();
    int lat, bsy;
    logic [31:0] ed;
    logic ee;
    @(negedge clk);
    issue(1'b0, 1'b1, 32'h1FF, 32'hDEADBEEF); wait_ready(lat, bsy); retire(ed, ee);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d want 3", lat); end
    n_checks++; if (bsy !== 3) begin n_fail++; $display("FAIL wr_busy_cycles: got %0d want 3", bsy); end
    n_checks++; if (mem_err !== ee) begin n_fail++; $display("FAIL wr_err: got %b want %b", mem_err, ee); end
    n_checks++; if (MDataIN !== ed) begin n_fail++; $display("FAIL wr_mdata_hold: got %h want %h", MDataIN, ed); end
    // Read issued in the write's DONE cycle.
    issue(1'b1, 1'b0, 32'h1FF, 32'h0); wait_ready(lat, bsy); retire(ed, ee);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d want 3", lat); end
    n_checks++; if (MDataIN !== ed || ed !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want DEADBEEF (model %h)", MDataIN, ed); end
    n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b want 0", mem_err); end
  endtask

  task automatic test_out_of_range();
    int lat, bsy;
    logic [31:0] ed;
    logic ee;
    @(negedge clk);
    issue(1'b1, 1'b0, 32'h00000200, 32'h0); wait_ready(lat, bsy); retire(ed, ee);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL oor_latency: got %0d want 3", lat); end
    n_checks++; if (mem_err !== 1'b1 || ee !== 1'b1) begin n_fail++; $display("FAIL oor_err: got %b want 1", mem_err); end
    n_checks++; if (MDataIN !== ed) begin n_fail++; $display("FAIL oor_mdata_hold: got %h want %h", MDataIN, ed); end
    @(negedge clk);
    n_checks++; if (mem_err !== 1'b0 || mem_ready !== 1'b0) begin n_fail++; $display("FAIL oor_pulse_width: got %b%b want 00", mem_ready, mem_err); end
  endtask

  task automatic test_conflict();
    int lat, bsy;
    logic [31:0] ed;
    logic ee;
    issue(1'b1, 1'b1, 32'h010, 32'h0); wait_ready(lat, bsy); retire(ed, ee);
    n_checks++; if (mem_err !== 1'b1 || ee !== 1'b1) begin n_fail++; $display("FAIL conflict_err: got %b want 1", mem_err); end
    n_checks++; if (MDataIN !== ed) begin n_fail++; $display("FAIL conflict_mdata_hold: got %h want %h", MDataIN, ed); end
    issue(1'b1, 1'b0, 32'h010, 32'h0); wait_ready(lat, bsy); retire(ed, ee);
    n_checks++; if (MDataIN !== ed || ed !== 32'hAAAA5555) begin n_fail++; $display("FAIL conflict_no_write: got %h want AAAA5555 (model %h)", MDataIN, ed); end
    n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL conflict_followup_err: got %b want 0", mem_err); end
  endtask

  task automatic test_ignored();
    int lat, bsy, nrdy, nbusy;
    logic [31:0] ed, seen;
    logic ee;
    @(negedge clk);
    issue(1'b1, 1'b0, 32'h001, 32'h0);
    nrdy = 0; nbusy = 0; seen = 'x;
    for (int c = 0; c < 10; c++) begin
      if (c == 1) begin write = 1'b1; MAR_Data = 32'h002; MDR_Data = 32'hFFFFFFFF; end
      if (c == 2) write = 1'b0;
      if (busy === 1'b1) nbusy++;
      if (mem_ready === 1'b1) begin nrdy++; seen = MDataIN; end
      @(negedge clk);
    end
    retire(ed, ee);
    n_checks++; if (nrdy !== 1) begin n_fail++; $display("FAIL ign_ready_count: got %0d want 1", nrdy); end
    n_checks++; if (nbusy !== 3) begin n_fail++; $display("FAIL ign_busy_cycles: got %0d want 3", nbusy); end
    n_checks++; if (seen !== ed || ed !== 32'h01010101) begin n_fail++; $display("FAIL ign_read_data: got %h want 01010101 (model %h)", seen, ed); end
    issue(1'b1, 1'b0, 32'h002, 32'h0); wait_ready(lat, bsy); retire(ed, ee);
    n_checks++; if (MDataIN !== ed || ed !== 32'h02020202) begin n_fail++; $display("FAIL ign_no_write: got %h want 02020202 (model %h)", MDataIN, ed); end
  endtask

  task automatic test_reset_abort();
    int lat, bsy, nrdy;
    logic [31:0] ed;
    logic ee;
    @(negedge clk);
    issue(1'b0, 1'b1, 32'h020, 32'h11111111);
    @(posedge clk);
    #1 clr = 1'b0;
    sb.delete();
    exp_rdata = 32'd0;
    @(negedge clk);
    clr = 1'b1;
    nrdy = 0;
    for (int c = 0; c < 6; c++) begin
      if (mem_ready === 1'b1) nrdy++;
      @(negedge clk);
    end
    n_checks++; if (nrdy !== 0) begin n_fail++; $display("FAIL abort_ready: got %0d pulses want 0", nrdy); end
    issue(1'b1, 1'b0, 32'h020, 32'h0); wait_ready(lat, bsy); retire(ed, ee);
    n_checks++; if (MDataIN !== ed || ed !== 32'h0) begin n_fail++; $display("FAIL abort_no_write: got %h want 0 (model %h)", MDataIN, ed); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL abort_read_latency: got %0d want 3", lat); end
  endtask

  task automatic test_back_to_back();
    int lat, bsy;
    logic [31:0] ed;
    logic ee;
    logic [31:0] addrs [4];
    addrs[0] = 32'h005; addrs[1] = 32'h1FF; addrs[2] = 32'h010; addrs[3] = 32'h001;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b0, addrs[i], 32'h0); wait_ready(lat, bsy); retire(ed, ee);
      n_checks++; if (lat !== 3 || MDataIN !== ed) begin n_fail++; $display("FAIL b2b_read[%0d]: got lat %0d data %h want lat 3 data %h", i, lat, MDataIN, ed); end
    end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || mem_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy %b ready %b want 0 0", busy, mem_ready); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_conflict();
    test_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
